// File: rtl/adt7320_spi_target.sv
// SPI mode-3 target emulating the ADT7320 register file. Pins are oversampled in the
// clk domain; sclk edges become one-clk strobes that drive a small framing FSM.
module adt7320_spi_target #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  ID_VALUE    = 8'hC3,
  parameter logic [15:0] TCRIT_RST   = 16'h4980,
  parameter logic [7:0]  THYST_RST   = 8'h05,
  parameter logic [15:0] THIGH_RST   = 16'h2000,
  parameter logic [15:0] TLOW_RST    = 16'h0500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        din,
  output logic        dout,
  output logic        dout_oe,
  input  logic [15:0] temp_value,
  input  logic [7:0]  status_in,
  output logic [7:0]  config_q,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CMD, DATA_RD, DATA_WR, DONE} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, din_sync;
  logic cs_s, sclk_s, din_s, cs_d, sclk_d;
  logic cs_fall, cs_rise, rise_ev, fall_ev, ones_hit, wide;
  logic [3:0]  bit_cnt, last_bit;
  logic [4:0]  ones_cnt;
  logic [2:0]  addr_q;
  logic        rd_q;
  logic [15:0] sh, rd_word, wr_word;
  logic [15:0] tcrit, thigh, tlow;
  logic [7:0]  thyst;

  // cs sync resets low so a cs still held low after reset never looks like a fresh fall;
  // the bus re-arms only on a genuine high-to-low transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync   <= '0;
      sclk_sync <= '1;
      din_sync  <= '0;
      cs_d      <= 1'b0;
      sclk_d    <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign rise_ev  = sclk_s & ~sclk_d & ~cs_rise;
  assign fall_ev  = ~sclk_s & sclk_d & ~cs_rise;
  assign ones_hit = rise_ev && (state != IDLE) && din_s && (ones_cnt == 5'd31);
  assign wide     = (addr_q == 3'd2) || (addr_q == 3'd4) || (addr_q == 3'd6) || (addr_q == 3'd7);
  assign last_bit = wide ? 4'd15 : 4'd7;
  assign wr_word  = {sh[14:0], din_s};

  always_comb begin
    rd_word = 16'h0000;
    case (addr_q)
      3'd0:    rd_word = {status_in, 8'h00};
      3'd1:    rd_word = {config_q, 8'h00};
      3'd2:    rd_word = temp_value;
      3'd3:    rd_word = {ID_VALUE, 8'h00};
      3'd4:    rd_word = tcrit;
      3'd5:    rd_word = {thyst, 8'h00};
      3'd6:    rd_word = thigh;
      default: rd_word = tlow;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_rise) state_nx = IDLE;
    else if (cs_fall || ones_hit) state_nx = CMD;
    else if (rise_ev) begin
      case (state)
        CMD:              if (bit_cnt == 4'd7) state_nx = rd_q ? DATA_RD : DATA_WR;
        DATA_RD, DATA_WR: if (bit_cnt == last_bit) state_nx = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout     <= 1'b1;
      dout_oe  <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      sh       <= '0;
      config_q <= 8'h00;
      tcrit    <= TCRIT_RST;
      thyst    <= THYST_RST;
      thigh    <= THIGH_RST;
      tlow     <= TLOW_RST;
    end else if (cs_rise) begin
      dout     <= 1'b1;
      dout_oe  <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (cs_fall) begin
      dout     <= 1'b1;
      dout_oe  <= 1'b1;
      busy     <= 1'b1;
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (state != IDLE) begin
      if (rise_ev) begin
        ones_cnt <= din_s ? ones_cnt + 5'd1 : 5'd0;
        if (ones_hit) begin
          ones_cnt <= '0;
          bit_cnt  <= '0;
          dout     <= 1'b1;
          config_q <= 8'h00;
          tcrit    <= TCRIT_RST;
          thyst    <= THYST_RST;
          thigh    <= THIGH_RST;
          tlow     <= TLOW_RST;
        end else begin
          case (state)
            CMD: begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd1) rd_q <= din_s;
              if (bit_cnt >= 4'd2 && bit_cnt <= 4'd4) addr_q <= {addr_q[1:0], din_s};
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                // Read data (including temp/status snapshot) is frozen at the last command bit.
                sh      <= rd_q ? rd_word : 16'h0000;
              end
            end
            DATA_RD: begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == last_bit) dout <= 1'b0;
            end
            DATA_WR: begin
              bit_cnt <= bit_cnt + 4'd1;
              sh      <= wr_word;
              if (bit_cnt == last_bit) begin
                dout <= 1'b0;
                case (addr_q)
                  3'd1: config_q <= wr_word[7:0];
                  3'd4: tcrit    <= wr_word;
                  3'd5: thyst    <= wr_word[7:0];
                  3'd6: thigh    <= wr_word;
                  3'd7: tlow     <= wr_word;
                  default: ;
                endcase
              end
            end
            default: ;
          endcase
        end
      end else if (fall_ev && state == DATA_RD) begin
        dout <= sh[15];
        sh   <= {sh[14:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_adt7320_spi_target.sv
// Drives SPI frames at clk/16 and checks reads, writes and resets against a register-array model.
module tb_adt7320_spi_target;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset, cs, sclk, din;
  logic dout, dout_oe, busy;
  logic [15:0] temp_value;
  logic [7:0]  status_in, config_q;

  int total = 0;
  int bad   = 0;
  logic [15:0] mregs [8];

  adt7320_spi_target dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .din(din),
    .dout(dout), .dout_oe(dout_oe), .temp_value(temp_value),
    .status_in(status_in), .config_q(config_q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int width(input logic [2:0] a);
    return (a == 3'd2 || a == 3'd4 || a == 3'd6 || a == 3'd7) ? 16 : 8;
  endfunction

  task automatic model_reset();
    mregs[0] = 16'h0; mregs[1] = 16'h0; mregs[2] = 16'h0; mregs[3] = 16'h00C3;
    mregs[4] = 16'h4980; mregs[5] = 16'h0005; mregs[6] = 16'h2000; mregs[7] = 16'h0500;
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] a);
    if (a == 3'd0) return {8'h00, status_in};
    if (a == 3'd2) return temp_value;
    return mregs[a];
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    wait_clk(6);
  endtask

  // MSB-first; dout is sampled just before each rising sclk, as the master would.
  task automatic shift(input logic [31:0] bits, input int n, output logic [31:0] got);
    got = '0;
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0;
      din  = bits[i];
      wait_clk(HALF);
      got  = {got[30:0], dout};
      sclk = 1'b1;
      wait_clk(HALF);
    end
    din = 1'b0;
  endtask

  task automatic frame_end(input string tag);
    wait_clk(2);
    chk({tag, "_done_dout"}, 32'(dout), 32'd0);
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    cs_high();
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_oe_lo"}, 32'(dout_oe), 32'd0);
  endtask

  task automatic do_read(input logic [2:0] a, input string tag);
    int w;
    logic [31:0] b, got, mask;
    logic [15:0] exp;
    w    = width(a);
    exp  = model_read(a);
    b    = 32'({1'b0, 1'b1, a, 3'($urandom)}) << w;
    mask = (32'd1 << w) - 32'd1;
    cs_low();
    shift(b, 8 + w, got);
    chk(tag, got & mask, 32'(exp));
    frame_end(tag);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] data, input string tag);
    int w;
    logic [31:0] b, got, mask;
    w    = width(a);
    mask = (32'd1 << w) - 32'd1;
    b    = (32'({1'b0, 1'b0, a, 3'($urandom)}) << w) | (32'(data) & mask);
    cs_low();
    shift(b, 8 + w, got);
    if (a == 3'd1 || a >= 3'd4) mregs[a] = 16'(32'(data) & mask);
    frame_end(tag);
    chk({tag, "_cfg"}, 32'(config_q), 32'(mregs[1][7:0]));
  endtask

  initial begin
    logic [31:0] got;
    reset = 1'b0; cs = 1'b1; sclk = 1'b1; din = 1'b0;
    temp_value = 16'h0; status_in = 8'h0;
    model_reset();
    wait_clk(3);
    chk("rst_dout", 32'(dout), 32'd1);
    chk("rst_oe", 32'(dout_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg", 32'(config_q), 32'h00);
    reset = 1'b1;
    wait_clk(4);

    do_read(3'd3, "rd_id");
    temp_value = 16'h0C80;
    do_read(3'd2, "rd_temp");
    do_write(3'd6, 16'h1234, "wr_thigh");
    do_read(3'd6, "rb_thigh");
    do_write(3'd3, 16'h0000, "wr_id");
    do_read(3'd3, "rb_id");

    // abort: config write cut after 4 data bits
    cs_low();
    shift(32'h08F, 12, got);
    cs_high();
    chk("abort_cfg", 32'(config_q), 32'(mregs[1][7:0]));
    chk("abort_oe", 32'(dout_oe), 32'd0);
    chk("abort_dout", 32'(dout), 32'd1);

    do_write(3'd1, 16'h0080, "wr_cfg");
    cs_low();
    shift(32'hFFFF_FFFF, 32, got);
    model_reset();
    chk("sreset_cfg", 32'(config_q), 32'h00);
    chk("sreset_oe", 32'(dout_oe), 32'd1);
    cs_high();
    do_read(3'd3, "sreset_id");
    do_read(3'd6, "sreset_thigh");

    do_write(3'd1, 16'h005A, "wr_cfg2");
    cs_low();
    shift(32'h5, 4, got);
    reset = 1'b0;
    #1;
    chk("midrst_oe", 32'(dout_oe), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cfg", 32'(config_q), 32'h00);
    model_reset();
    wait_clk(2);
    cs = 1'b1; sclk = 1'b1;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(4);
    temp_value = 16'hABCD;
    do_read(3'd2, "midrst_next");

    for (int k = 0; k < 40; k++) begin
      logic [2:0] a;
      a          = 3'($urandom_range(0, 7));
      temp_value = 16'($urandom);
      status_in  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_read(a, "rnd_rd");
      else do_write(a, 16'($urandom), "rnd_wr");
    end
    for (int a = 0; a < 8; a++) do_read(3'(a), "final_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
